// File: rtl/fff_lock_controller_if.sv
`timescale 1ns/1ps
// Host/encoder-facing signal bundle for the fastest-finger-first round controller.
// The master side (host + priority encoder) drives start/clear/code_in; the
// slave side (fff_lock_controller) drives the round status outputs.
interface fff_lock_controller_if #(
  parameter int unsigned CODE_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic              clear;
  logic [CODE_W-1:0] code_in;
  logic [1:0]        state;
  logic [CODE_W-1:0] winner;
  logic              winner_valid;
  logic              buzzer;
  logic              foul;
  logic [CODE_W-1:0] foul_id;
  logic              timeout;
  logic [CNT_W-1:0]  time_left;

  modport master (
    output start, clear, code_in,
    input  state, winner, winner_valid, buzzer, foul, foul_id, timeout, time_left
  );

  modport slave (
    input  start, clear, code_in,
    output state, winner, winner_valid, buzzer, foul, foul_id, timeout, time_left
  );
endinterface

// File: rtl/fff_lock_controller.sv
`timescale 1ns/1ps
// Round controller and first-press latch for the fastest-finger-first game.
// A glitch filter qualifies encoder codes (STABLE_CYC identical valid samples),
// the FSM arms on start, locks the first accepted code as winner, reports early
// presses as fouls, and runs the winner's answer timer.
module fff_lock_controller #(
  parameter int unsigned       N_PLAYERS  = 10,
  parameter int unsigned       CODE_W     = 4,
  parameter logic [CODE_W-1:0] NONE_CODE  = 4'hF,
  parameter int unsigned       STABLE_CYC = 2,
  parameter int unsigned       ANSWER_CYC = 1000,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fff_lock_controller_if.slave bus
);

  localparam int unsigned       STB_W  = $clog2(STABLE_CYC + 1);
  localparam logic [STB_W-1:0]  STB    = STB_W'(STABLE_CYC);
  localparam logic [CODE_W:0]   NPLAY  = (CODE_W + 1)'(N_PLAYERS);
  localparam logic [CNT_W-1:0]  ANS_M1 = CNT_W'(ANSWER_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LOCKED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t            r_state;
  logic [CODE_W-1:0] r_cand;
  logic [STB_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_winner;
  logic [CODE_W-1:0] r_foul_id;
  logic [CNT_W-1:0]  r_time_left;
  logic              r_winner_valid;
  logic              r_buzzer;
  logic              r_foul;
  logic              r_timeout;

  logic              w_valid;
  logic              w_same;
  logic [STB_W-1:0]  w_cnt_nxt;
  logic [CODE_W-1:0] w_cand_nxt;
  logic              w_accept;

  // Glitch filter next-state: count identical valid samples, saturating at
  // STABLE_CYC; accept fires only on the edge the count first reaches it.
  always_comb begin
    w_valid    = ({1'b0, bus.code_in} < NPLAY);
    w_same     = w_valid && (bus.code_in == r_cand);
    w_cnt_nxt  = '0;
    w_cand_nxt = r_cand;
    if (w_same) begin
      w_cnt_nxt = (r_cnt == STB) ? STB : r_cnt + STB_W'(1);
    end else begin
      w_cand_nxt = bus.code_in;
      w_cnt_nxt  = w_valid ? STB_W'(1) : '0;
    end
    w_accept = (w_cnt_nxt == STB) && (r_cnt != STB);
  end

  // Round FSM with filter state and all registered outputs; clear overrides everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cand         <= NONE_CODE;
      r_cnt          <= '0;
      r_winner       <= NONE_CODE;
      r_foul_id      <= NONE_CODE;
      r_time_left    <= '0;
      r_winner_valid <= 1'b0;
      r_buzzer       <= 1'b0;
      r_foul         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_buzzer <= 1'b0;
      r_foul   <= 1'b0;
      r_cand   <= w_cand_nxt;
      r_cnt    <= w_cnt_nxt;
      if (bus.clear) begin
        r_state        <= S_IDLE;
        r_cand         <= NONE_CODE;
        r_cnt          <= '0;
        r_winner       <= NONE_CODE;
        r_foul_id      <= NONE_CODE;
        r_time_left    <= '0;
        r_winner_valid <= 1'b0;
        r_timeout      <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              // Zeroing the filter means a button already held is re-qualified from scratch.
              r_state <= S_ARMED;
              r_cand  <= NONE_CODE;
              r_cnt   <= '0;
            end else if (w_accept) begin
              r_foul    <= 1'b1;
              r_foul_id <= w_cand_nxt;
            end
          end
          S_ARMED: begin
            if (w_accept) begin
              r_state        <= S_LOCKED;
              r_winner       <= w_cand_nxt;
              r_buzzer       <= 1'b1;
              r_time_left    <= ANS_M1;
              r_winner_valid <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (r_time_left == '0) begin
              r_state   <= S_EXPIRED;
              r_timeout <= 1'b1;
            end else begin
              r_time_left <= r_time_left - CNT_W'(1);
            end
          end
          S_EXPIRED: begin
            r_state <= S_EXPIRED;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.state        = r_state;
  assign bus.winner       = r_winner;
  assign bus.winner_valid = r_winner_valid;
  assign bus.buzzer       = r_buzzer;
  assign bus.foul         = r_foul;
  assign bus.foul_id      = r_foul_id;
  assign bus.timeout      = r_timeout;
  assign bus.time_left    = r_time_left;

endmodule

// File: tb/tb_fff_lock_controller.sv
`timescale 1ns/1ps
// Bench for fff_lock_controller: two instances (answer window 1000 and 4)
// share one stimulus stream and are compared every cycle against a
// run-length / lock-timestamp reference model.
module tb_fff_lock_controller;

  localparam int STABLE = 2;
  localparam int NPL    = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fff_lock_controller_if #(.CODE_W(4), .CNT_W(16)) ifa ();
  fff_lock_controller_if #(.CODE_W(4), .CNT_W(16)) ifb ();

  assign ifb.start   = ifa.start;
  assign ifb.clear   = ifa.clear;
  assign ifb.code_in = ifa.code_in;

  fff_lock_controller #(.ANSWER_CYC(1000)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  fff_lock_controller #(.ANSWER_CYC(4))    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model: per instance, state number, run length of current code,
  // and the edge index at which the winner locked.
  int ans[2] = '{1000, 4};
  int cyc = 0;
  int m_state[2], m_run[2], m_code[2], m_lock[2], m_winner[2], m_fid[2];
  bit m_buzz[2], m_foul[2];

  localparam logic [29:0] RESET_VEC = {2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 16'd0};

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_run[k] = 0; m_code[k] = 15; m_lock[k] = 0;
      m_winner[k] = 15; m_fid[k] = 15; m_buzz[k] = 0; m_foul[k] = 0;
    end
  endtask

  task automatic model_edge(input bit st, input bit cl, input int code);
    bit valid, acc;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      m_buzz[k] = 0;
      m_foul[k] = 0;
      if (cl) begin
        m_state[k] = 0; m_winner[k] = 15; m_fid[k] = 15; m_run[k] = 0; m_code[k] = 15;
      end else begin
        valid = (code < NPL);
        if (valid && code == m_code[k]) begin
          if (m_run[k] < 1000000) m_run[k]++;
        end else begin
          m_code[k] = code;
          m_run[k]  = valid ? 1 : 0;
        end
        acc = (m_run[k] == STABLE);
        case (m_state[k])
          0: if (st) begin
               m_state[k] = 1; m_run[k] = 0; m_code[k] = 15;
             end else if (acc) begin
               m_foul[k] = 1; m_fid[k] = code;
             end
          1: if (acc) begin
               m_state[k] = 2; m_winner[k] = code; m_buzz[k] = 1; m_lock[k] = cyc;
             end
          2: if (cyc - m_lock[k] >= ans[k]) m_state[k] = 3;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [29:0] exp_vec(input int k);
    int tl;
    tl = (m_state[k] == 2) ? (ans[k] - 1 - (cyc - m_lock[k])) : 0;
    return {2'(m_state[k]), 4'(m_winner[k]), m_state[k] >= 2, m_buzz[k], m_foul[k],
            4'(m_fid[k]), m_state[k] == 3, 16'(tl)};
  endfunction

  function automatic logic [29:0] obs_vec(input int k);
    if (k == 0)
      return {ifa.state, ifa.winner, ifa.winner_valid, ifa.buzzer, ifa.foul,
              ifa.foul_id, ifa.timeout, ifa.time_left};
    return {ifb.state, ifb.winner, ifb.winner_valid, ifb.buzzer, ifb.foul,
            ifb.foul_id, ifb.timeout, ifb.time_left};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle past it.
  task automatic step(input bit st, input bit cl, input int code);
    ifa.start   = st;
    ifa.clear   = cl;
    ifa.code_in = 4'(code);
    @(posedge clk);
    model_edge(st, cl, code);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs_vec(k) !== RESET_VEC) begin
        mismatched++;
        $display("FAIL reset_state inst=%0d got=%h exp=%h", k, obs_vec(k), RESET_VEC);
      end
    end
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_lock_basic();
    step(1, 0, 15);
    step(0, 0, 3);
    compared++;
    if (ifa.state !== 2'd1) begin
      mismatched++; $display("FAIL lock_not_early got=%0d exp=1", ifa.state);
    end
    step(0, 0, 3);
    compared++;
    if ({ifa.state, ifa.winner, ifa.buzzer, ifa.time_left} !== {2'd2, 4'd3, 1'b1, 16'd999}) begin
      mismatched++;
      $display("FAIL lock_edge got st=%0d w=%0d bz=%0d tl=%0d exp st=2 w=3 bz=1 tl=999",
               ifa.state, ifa.winner, ifa.buzzer, ifa.time_left);
    end
    step(0, 0, 3);
    compared++;
    if ({ifa.buzzer, ifa.time_left} !== {1'b0, 16'd998}) begin
      mismatched++;
      $display("FAIL buzzer_pulse got bz=%0d tl=%0d exp bz=0 tl=998", ifa.buzzer, ifa.time_left);
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs_vec(k) !== exp_vec(k)) begin
        mismatched++; $display("FAIL lock_model inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
    step(0, 1, 15);
  endtask

  task automatic test_glitch();
    int codes[8] = '{5, 7, 5, 7, 2, 15, 7, 7};
    step(1, 0, 15);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, codes[i]);
      if (i == 5) begin
        compared++;
        if (ifa.state !== 2'd1) begin
          mismatched++; $display("FAIL glitch_no_lock got=%0d exp=1", ifa.state);
        end
      end
      compared++;
      if (obs_vec(0) !== exp_vec(0)) begin
        mismatched++; $display("FAIL glitch_model i=%0d got=%h exp=%h", i, obs_vec(0), exp_vec(0));
      end
    end
    compared++;
    if ({ifa.state, ifa.winner} !== {2'd2, 4'd7}) begin
      mismatched++; $display("FAIL glitch_winner got st=%0d w=%0d exp st=2 w=7", ifa.state, ifa.winner);
    end
    step(0, 1, 15);
  endtask

  task automatic test_foul();
    int pulses = 0;
    bit st_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 2);
      if (ifa.foul) pulses++;
      if (ifa.state !== 2'd0) st_bad = 1;
    end
    step(0, 0, 15);
    compared++;
    if (pulses != 1 || st_bad || ifa.foul_id !== 4'd2) begin
      mismatched++;
      $display("FAIL foul_single got pulses=%0d st_bad=%0d id=%0d exp pulses=1 st_bad=0 id=2",
               pulses, st_bad, ifa.foul_id);
    end
    compared++;
    if (obs_vec(0) !== exp_vec(0)) begin
      mismatched++; $display("FAIL foul_model got=%h exp=%h", obs_vec(0), exp_vec(0));
    end
    step(0, 1, 15);
    compared++;
    if (ifa.foul_id !== 4'hF) begin
      mismatched++; $display("FAIL foul_clear got=%h exp=f", ifa.foul_id);
    end
  endtask

  task automatic test_timer();
    int exp_tl[4] = '{3, 2, 1, 0};
    step(1, 0, 15);
    step(0, 0, 4);
    step(0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({ifb.state, ifb.time_left} !== {2'd2, 16'(exp_tl[i])}) begin
        mismatched++;
        $display("FAIL timer_count i=%0d got st=%0d tl=%0d exp st=2 tl=%0d", i, ifb.state, ifb.time_left, exp_tl[i]);
      end
      step(0, 0, 6);
    end
    compared++;
    if ({ifb.state, ifb.timeout, ifb.winner, ifb.time_left, ifb.foul} !== {2'd3, 1'b1, 4'd4, 16'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL timer_expire got st=%0d to=%0d w=%0d tl=%0d foul=%0d exp st=3 to=1 w=4 tl=0 foul=0",
               ifb.state, ifb.timeout, ifb.winner, ifb.time_left, ifb.foul);
    end
    step(0, 0, 6);
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs_vec(k) !== exp_vec(k)) begin
        mismatched++; $display("FAIL timer_model inst=%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
    step(0, 1, 15);
  endtask

  task automatic test_clear_priority();
    step(1, 0, 15);
    step(0, 0, 4);
    step(0, 0, 4);
    step(1, 1, 4);
    compared++;
    if ({ifa.state, ifa.winner, ifa.winner_valid} !== {2'd0, 4'hF, 1'b0}) begin
      mismatched++;
      $display("FAIL clear_over_start got st=%0d w=%h wv=%0d exp st=0 w=f wv=0", ifa.state, ifa.winner, ifa.winner_valid);
    end
    step(1, 0, 15);
    step(0, 0, 3);
    step(0, 1, 3);
    compared++;
    if ({ifa.state, ifa.buzzer, ifa.winner} !== {2'd0, 1'b0, 4'hF}) begin
      mismatched++;
      $display("FAIL clear_over_accept got st=%0d bz=%0d w=%h exp st=0 bz=0 w=f", ifa.state, ifa.buzzer, ifa.winner);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 3);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs_vec(k) !== exp_vec(k)) begin
          mismatched++; $display("FAIL clear_model i=%0d inst=%0d got=%h exp=%h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
    step(0, 1, 15);
  endtask

  task automatic test_async_reset();
    step(1, 0, 15);
    step(0, 0, 8);
    step(0, 0, 8);
    step(0, 0, 8);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (obs_vec(k) !== RESET_VEC) begin
        mismatched++; $display("FAIL async_reset inst=%0d got=%h exp=%h", k, obs_vec(k), RESET_VEC);
      end
    end
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    int code = 15;
    bit st, cl;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) code = $urandom_range(0, 15);
      step(st, cl, code);
      for (int k = 0; k < 2; k++) begin
        compared++;
        if (obs_vec(k) !== exp_vec(k)) begin
          mismatched++; $display("FAIL random i=%0d inst=%0d got=%h exp=%h", i, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    ifa.start   = 1'b0;
    ifa.clear   = 1'b0;
    ifa.code_in = 4'hF;
    model_reset();
    #12;
    test_reset();
    test_lock_basic();
    test_glitch();
    test_foul();
    test_timer();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
